// File: rtl/gold_lfsr_gen_if.sv
// Gold-code LFSR branch interface.
// Groups the control, fill and sequence-output signals of one gold_lfsr_gen.
//   Enable     : advance the sequence by STEP bits this cycle
//   Fill_En    : parallel-load Fill_Data into the state and seed registers
//   Fill_Data  : new fill value (LEN bits)
//   Seq_Out    : STEP sequence bits, bit 0 earliest in time
//   Seq_Valid  : Seq_Out is valid this cycle
//   Epoch      : one-cycle pulse on the last output word of an epoch
//   Lock_Err   : state register is all zero
// master drives the controls (testbench / sequencer), slave is the generator.
interface gold_lfsr_gen_if #(
  parameter int unsigned LEN  = 26,
  parameter int unsigned STEP = 1
);
  logic            Enable;
  logic            Fill_En;
  logic [LEN-1:0]  Fill_Data;
  logic [STEP-1:0] Seq_Out;
  logic            Seq_Valid;
  logic            Epoch;
  logic            Lock_Err;

  modport master (
    output Enable, Fill_En, Fill_Data,
    input  Seq_Out, Seq_Valid, Epoch, Lock_Err
  );

  modport slave (
    input  Enable, Fill_En, Fill_Data,
    output Seq_Out, Seq_Valid, Epoch, Lock_Err
  );
endinterface

// File: rtl/gold_lfsr_gen.sv
// Parametrised Fibonacci LFSR sequence generator for one Gold-code branch.
// Produces STEP bits per Enable cycle, supports single-cycle parallel fill,
// an epoch counter that reloads the last fill (or SEED) every EPOCH Enables,
// and all-zero lock-up detection with optional recovery to SEED.
// Ports:
//   Clock : rising-edge clock
//   Reset : synchronous, active-high reset
//   bus   : gold_lfsr_gen_if slave (Enable, Fill_En, Fill_Data in;
//           Seq_Out, Seq_Valid, Epoch, Lock_Err out, all registered)
module gold_lfsr_gen #(
  parameter int unsigned    LEN          = 26,
  parameter logic [LEN-1:0] TAPS         = 26'h2000008,
  parameter int unsigned    STEP         = 1,
  parameter logic [LEN-1:0] SEED         = 26'h0000001,
  parameter int unsigned    EPOCH        = 0,
  parameter int unsigned    CNT_W        = 16,
  parameter bit             AUTO_RECOVER = 1'b1
) (
  input logic           Clock,
  input logic           Reset,
  gold_lfsr_gen_if.slave bus
);

  localparam bit             EpochOn   = (EPOCH != 0);
  // Truncated value is only used when EpochOn is set.
  localparam logic [CNT_W-1:0] EpochLast = CNT_W'(EPOCH - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [LEN-1:0]   state_q, state_d;
  logic [LEN-1:0]   seed_q, seed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STEP-1:0]  out_q, out_d;
  logic             valid_q, valid_d;
  logic             epoch_q, epoch_d;
  logic             lock_q, lock_d;

  logic [STEP-1:0]  step_bits;
  logic [LEN-1:0]   adv_state;
  logic             epoch_hit;

  // STEP Fibonacci steps unrolled: output the MSB, shift left, feed back the
  // tap parity into bit 0.
  always_comb begin
    logic [LEN-1:0] s;
    s         = state_q;
    step_bits = '0;
    for (int k = 0; k < int'(STEP); k++) begin
      step_bits[k] = s[LEN-1];
      s            = {s[LEN-2:0], ^(s & TAPS)};
    end
    adv_state = s;
  end

  assign epoch_hit = EpochOn && (cnt_q == EpochLast);

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    epoch_d = 1'b0;

    if (bus.Fill_En) begin
      // Fill has priority over Enable; no output word this cycle.
      state_d = bus.Fill_Data;
      seed_d  = bus.Fill_Data;
      cnt_d   = '0;
    end else if (bus.Enable) begin
      if (AUTO_RECOVER && (state_q == '0)) begin
        state_d = SEED;
        cnt_d   = '0;
      end else if (epoch_hit) begin
        // Last word of the epoch comes from the current state, then restart
        // from the last loaded seed rather than the advanced state.
        out_d   = step_bits;
        valid_d = 1'b1;
        epoch_d = 1'b1;
        state_d = seed_q;
        cnt_d   = '0;
      end else begin
        out_d   = step_bits;
        valid_d = 1'b1;
        state_d = adv_state;
        if (EpochOn) begin
          cnt_d = cnt_q + CntOne;
        end
      end
    end

    // Registered alongside the state so it describes the current state_q.
    lock_d = (state_d == '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= SEED;
      seed_q  <= SEED;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      epoch_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      epoch_q <= epoch_d;
      lock_q  <= lock_d;
    end
  end

  assign bus.Seq_Out   = out_q;
  assign bus.Seq_Valid = valid_q;
  assign bus.Epoch     = epoch_q;
  assign bus.Lock_Err  = lock_q;

endmodule

// File: tb/tb_gold_lfsr_gen.sv
// Directed bench for gold_lfsr_gen: default 26-stage branch plus four
// 4-stage (x^4 taps 3,0, seed 0001) variants covering STEP=4, epochs and
// lock-up handling with and without recovery.
module tb_gold_lfsr_gen;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  // Output bit k of the 4-stage sequence starting at 0001 (period 15).
  logic [14:0] seq_tab;
  // Output bits starting at 0110: 0,1,1,0,0.
  logic [4:0]  seq_0110;

  gold_lfsr_gen_if #(.LEN(26), .STEP(1)) if_d ();
  gold_lfsr_gen_if #(.LEN(4),  .STEP(1)) if_a ();
  gold_lfsr_gen_if #(.LEN(4),  .STEP(4)) if_b ();
  gold_lfsr_gen_if #(.LEN(4),  .STEP(1)) if_e ();
  gold_lfsr_gen_if #(.LEN(4),  .STEP(1)) if_n ();

  gold_lfsr_gen u_dflt (.Clock(clk), .Reset(rst), .bus(if_d));

  gold_lfsr_gen #(
    .LEN(4), .TAPS(4'b1001), .STEP(1), .SEED(4'b0001), .EPOCH(0), .CNT_W(4), .AUTO_RECOVER(1'b1)
  ) u_p1 (.Clock(clk), .Reset(rst), .bus(if_a));

  gold_lfsr_gen #(
    .LEN(4), .TAPS(4'b1001), .STEP(4), .SEED(4'b0001), .EPOCH(0), .CNT_W(4), .AUTO_RECOVER(1'b1)
  ) u_p4 (.Clock(clk), .Reset(rst), .bus(if_b));

  gold_lfsr_gen #(
    .LEN(4), .TAPS(4'b1001), .STEP(1), .SEED(4'b0001), .EPOCH(5), .CNT_W(4), .AUTO_RECOVER(1'b1)
  ) u_ep (.Clock(clk), .Reset(rst), .bus(if_e));

  gold_lfsr_gen #(
    .LEN(4), .TAPS(4'b1001), .STEP(1), .SEED(4'b0001), .EPOCH(0), .CNT_W(4), .AUTO_RECOVER(1'b0)
  ) u_nr (.Clock(clk), .Reset(rst), .bus(if_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    seq_tab  = 15'b100110101111000;
    seq_0110 = 5'b00110;

    rst = 1'b1;
    if_d.Enable = 1'b0; if_d.Fill_En = 1'b0; if_d.Fill_Data = '0;
    if_a.Enable = 1'b0; if_a.Fill_En = 1'b0; if_a.Fill_Data = '0;
    if_b.Enable = 1'b0; if_b.Fill_En = 1'b0; if_b.Fill_Data = '0;
    if_e.Enable = 1'b0; if_e.Fill_En = 1'b0; if_e.Fill_Data = '0;
    if_n.Enable = 1'b0; if_n.Fill_En = 1'b0; if_n.Fill_Data = '0;
    tick();
    tick();

    check("rst_out",   64'(if_d.Seq_Out),   64'd0);
    check("rst_valid", 64'(if_d.Seq_Valid), 64'd0);
    check("rst_epoch", 64'(if_d.Epoch),     64'd0);
    check("rst_lock",  64'(if_d.Lock_Err),  64'd0);
    rst = 1'b0;

    // Default branch: 25 zeros then the seed bit reaches stage 25.
    if_d.Enable = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      tick();
      check($sformatf("dflt_out%0d", i), 64'(if_d.Seq_Out), (i == 26) ? 64'd1 : 64'd0);
      check("dflt_valid", 64'(if_d.Seq_Valid), 64'd1);
      check("dflt_lock",  64'(if_d.Lock_Err),  64'd0);
    end
    if_d.Enable = 1'b0;
    tick();
    check("dflt_idle_valid", 64'(if_d.Seq_Valid), 64'd0);
    check("dflt_idle_hold",  64'(if_d.Seq_Out),   64'd1);

    // Period-15 sequence, observed over two full periods.
    if_a.Enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check($sformatf("p1_out%0d", i), 64'(if_a.Seq_Out), 64'(seq_tab[i % 15]));
      check("p1_valid", 64'(if_a.Seq_Valid), 64'd1);
    end
    if_a.Enable = 1'b0;
    tick();
    check("p1_idle_valid", 64'(if_a.Seq_Valid), 64'd0);

    // STEP=4: four words of four bits, bit 0 earliest.
    if_b.Enable = 1'b1;
    tick(); check("p4_w1", 64'(if_b.Seq_Out), 64'h8);
    tick(); check("p4_w2", 64'(if_b.Seq_Out), 64'h7);
    tick(); check("p4_w3", 64'(if_b.Seq_Out), 64'hd);
    tick(); check("p4_w4", 64'(if_b.Seq_Out), 64'h4);
    check("p4_valid", 64'(if_b.Seq_Valid), 64'd1);
    if_b.Enable = 1'b0;

    // EPOCH=5: words 6..10 repeat words 1..5, pulse on 5th and 10th.
    if_e.Enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("ep_out%0d", i),   64'(if_e.Seq_Out), 64'(seq_tab[i % 5]));
      check($sformatf("ep_epoch%0d", i), 64'(if_e.Epoch),   (i % 5 == 4) ? 64'd1 : 64'd0);
    end
    tick(); check("ep_mid_out0", 64'(if_e.Seq_Out), 64'd0);
    tick(); check("ep_mid_out1", 64'(if_e.Seq_Out), 64'd0);
    if_e.Enable = 1'b0;
    if_e.Fill_En = 1'b1;
    if_e.Fill_Data = 4'b0110;
    tick();
    check("ep_fill_valid", 64'(if_e.Seq_Valid), 64'd0);
    check("ep_fill_epoch", 64'(if_e.Epoch),     64'd0);
    if_e.Fill_En = 1'b0;
    if_e.Enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("ep_f_out%0d", i),   64'(if_e.Seq_Out), 64'(seq_0110[i % 5]));
      check($sformatf("ep_f_epoch%0d", i), 64'(if_e.Epoch),   (i % 5 == 4) ? 64'd1 : 64'd0);
    end
    tick(); check("ep_pre_rst0", 64'(if_e.Seq_Out), 64'd0);
    tick(); check("ep_pre_rst1", 64'(if_e.Seq_Out), 64'd1);
    if_e.Enable = 1'b0;

    // Zero fill with recovery on u_p1 (currently back at seed 0001).
    if_a.Fill_En = 1'b1;
    if_a.Fill_Data = 4'b0000;
    tick();
    check("zr_lock",  64'(if_a.Lock_Err),  64'd1);
    check("zr_valid", 64'(if_a.Seq_Valid), 64'd0);
    if_a.Fill_En = 1'b0;
    if_a.Enable = 1'b1;
    tick();
    check("zr_rec_valid", 64'(if_a.Seq_Valid), 64'd0);
    check("zr_rec_lock",  64'(if_a.Lock_Err),  64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("zr_out%0d", i), 64'(if_a.Seq_Out), 64'(seq_tab[i]));
    end
    if_a.Enable = 1'b0;

    // Zero fill without recovery: zeros stream out, lock stays high.
    if_n.Fill_En = 1'b1;
    if_n.Fill_Data = 4'b0000;
    tick();
    check("nr_fill_lock", 64'(if_n.Lock_Err), 64'd1);
    if_n.Fill_En = 1'b0;
    if_n.Enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nr_out",   64'(if_n.Seq_Out),   64'd0);
      check("nr_valid", 64'(if_n.Seq_Valid), 64'd1);
      check("nr_lock",  64'(if_n.Lock_Err),  64'd1);
    end
    if_n.Enable = 1'b0;

    // Fill and Enable together: fill wins, next Enable outputs Fill_Data[3].
    if_a.Fill_En = 1'b1;
    if_a.Enable = 1'b1;
    if_a.Fill_Data = 4'b1000;
    tick();
    check("fe_valid", 64'(if_a.Seq_Valid), 64'd0);
    if_a.Fill_En = 1'b0;
    tick();
    check("fe_out1",   64'(if_a.Seq_Out),   64'd1);
    check("fe_valid1", 64'(if_a.Seq_Valid), 64'd1);
    tick();
    check("fe_out2", 64'(if_a.Seq_Out), 64'd0);
    if_a.Enable = 1'b0;

    // Reset with Fill_En: reset wins and SEED is restored everywhere.
    rst = 1'b1;
    if_a.Fill_En = 1'b1;
    if_a.Fill_Data = 4'b1010;
    tick();
    check("rf_out",   64'(if_a.Seq_Out),   64'd0);
    check("rf_valid", 64'(if_a.Seq_Valid), 64'd0);
    check("rf_lock",  64'(if_a.Lock_Err),  64'd0);
    rst = 1'b0;
    if_a.Fill_En = 1'b0;
    if_a.Enable = 1'b1;
    if_e.Enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) begin
        check($sformatf("rf_out%0d", i), 64'(if_a.Seq_Out), 64'(seq_tab[i]));
      end
      check($sformatf("er_out%0d", i),   64'(if_e.Seq_Out), 64'(seq_tab[i]));
      check($sformatf("er_epoch%0d", i), 64'(if_e.Epoch),   (i == 4) ? 64'd1 : 64'd0);
    end
    if_a.Enable = 1'b0;
    if_e.Enable = 1'b0;
    tick();
    check("end_ep_valid", 64'(if_e.Seq_Valid), 64'd0);
    check("end_ep_epoch", 64'(if_e.Epoch),     64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
